// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//  - RV32I funct3 width codes used by loads and stores
//  - lsu_state_t: load/store FSM states
//  - f3_illegal / f3_misaligned: request classification helpers
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    RMW_RD,
    RMW_MRG,
    ST_WR,
    DONE
  } lsu_state_t;

  // Width codes with no meaning for the given direction. Stores have no
  // unsigned variants, so any funct3[2]=1 store is illegal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ill;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (we && f3[2]) ill = 1'b1;
    return ill;
  endfunction

  // Natural-alignment check for halves and words.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H || f3 == F3_HU) && off[0]) mis = 1'b1;
    if (f3 == F3_W && off != 2'b00)            mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte/half lane logic.
//  funct3_i : width code of the current request
//  off_i    : byte offset within the word (addr[1:0])
//  word_i   : word read from RAM
//  wdata_i  : store data (rs2)
//  load_o   : extracted and sign/zero-extended load result
//  merge_o  : word_i with the store byte/half inserted (full wdata_i for words)
// Halves select by off_i[1] only, so a half at an odd address uses the
// half containing it.
module lsu_lane
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  bv;
  logic [15:0] hv;

  always_comb begin
    bsh = {off_i, 3'b000};
    hsh = {off_i[1], 4'b0000};
    bv  = word_i[bsh +: 8];
    hv  = word_i[hsh +: 16];

    case (funct3_i)
      F3_B:    load_o = {{24{bv[7]}}, bv};
      F3_BU:   load_o = {24'h0, bv};
      F3_H:    load_o = {{16{hv[15]}}, hv};
      F3_HU:   load_o = {16'h0, hv};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    if (funct3_i == F3_B)      merge_o[bsh +: 8]  = wdata_i[7:0];
    else if (funct3_i == F3_H) merge_o[hsh +: 16] = wdata_i[15:0];
    else                       merge_o = wdata_i;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-wide synchronous data RAM with a
// 1-cycle read latency. Takes one request at a time from execute.
//  clock, nReset       : clock, async active-low reset
//  req/we/funct3/addr/wdata : request (sampled only while idle)
//  busy, done, rdata   : status, 1-cycle completion pulse, load result
//  misaligned          : pulses with done on a trapped misaligned request
//  ramR, ramW, ramAddr, ramDataW, ramDataR : RAM port
// Optional feature: define MISALIGN_TRAP_EN to turn misaligned half/word
// requests into RAM-less completions flagged by misaligned. Undefined, the
// low address bits are ignored and misaligned is tied 0.
// Sub-byte stores are read-modify-write since the RAM writes whole words.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int RAM_ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  ramR,
  output logic                  ramW,
  output logic [RAM_ADDR_W-1:0] ramAddr,
  output logic [31:0]           ramDataW,
  input  logic [31:0]           ramDataR
);

  lsu_state_t            state_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           ramDataW_q;
  logic [RAM_ADDR_W-1:0] ramAddr_q;
  logic                  done_q;
  logic                  ramR_q;
  logic                  ramW_q;
  logic [RAM_ADDR_W-1:0] waddr;
  logic [31:0]           ld_fmt;
  logic [31:0]           st_mrg;
  logic                  illegal;
  logic                  trap;

  // Word address: byte address >> 2, zero-extended or truncated.
  always_comb begin
    waddr = '0;
    for (int i = 0; i < RAM_ADDR_W && i < 30; i++) waddr[i] = addr[i+2];
  end

  assign illegal = f3_illegal(we, funct3);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = !illegal && f3_misaligned(funct3, addr[1:0]);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) mis_q <= 1'b0;
    else         mis_q <= (state_q == IDLE) && req && trap;
  end
  assign misaligned = mis_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  lsu_lane u_lane (
    .funct3_i (f3_q),
    .off_i    (off_q),
    .word_i   (ramDataR),
    .wdata_i  (wdata_q),
    .load_o   (ld_fmt),
    .merge_o  (st_mrg)
  );

  // RAM strobes and done are set together with the state they belong to,
  // so they are registered Moore outputs with no combinational path.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      ramDataW_q <= 32'h0;
      ramAddr_q  <= '0;
      done_q     <= 1'b0;
      ramR_q     <= 1'b0;
      ramW_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ramR_q <= 1'b0;
      ramW_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          f3_q      <= funct3;
          off_q     <= addr[1:0];
          wdata_q   <= wdata;
          ramAddr_q <= waddr;
          if (illegal || trap) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!we) begin
            state_q <= LD_RD;
            ramR_q  <= 1'b1;
          end else if (funct3 == F3_W) begin
            state_q    <= ST_WR;
            ramW_q     <= 1'b1;
            ramDataW_q <= wdata;
          end else begin
            state_q <= RMW_RD;
            ramR_q  <= 1'b1;
          end
        end
        LD_RD:   state_q <= LD_CAP;
        LD_CAP: begin
          rdata_q <= ld_fmt;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        RMW_RD:  state_q <= RMW_MRG;
        RMW_MRG: begin
          ramDataW_q <= st_mrg;
          state_q    <= ST_WR;
          ramW_q     <= 1'b1;
        end
        ST_WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign ramR     = ramR_q;
  assign ramW     = ramW_q;
  assign ramAddr  = ramAddr_q;
  assign ramDataW = ramDataW_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous 1-cycle-read RAM model
// (word 5 preset to 0x0000000F) and a scoreboard of expected load results.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, ramR, ramW;
  logic [31:0] rdata, ramAddr, ramDataW;
  logic [31:0] ramDataR = 32'h0;

  logic [31:0] mem [0:15] = '{5: 32'h0000000F, default: 32'h0};
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;
  logic        both_hi = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] prev_exp = 32'h0;

  load_store_unit #(.RAM_ADDR_W(32)) dut (
    .clock(clock), .nReset(nReset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .ramR(ramR), .ramW(ramW), .ramAddr(ramAddr),
    .ramDataW(ramDataW), .ramDataR(ramDataR)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ramR) begin
      ramDataR <= mem[ramAddr[3:0]];
      rd_cnt   <= rd_cnt + 1;
    end
    if (ramW) begin
      mem[ramAddr[3:0]] <= ramDataW;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= ramAddr;
      last_wd <= ramDataW;
    end
    if (ramR && ramW) both_hi <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: drive, accept, wait for done, check latency, RAM access
  // counts and strobe cycles (0 = no strobe expected), and the popped
  // scoreboard entry for loads.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_cyc, input int exp_rcyc, input int exp_wcyc,
                      input logic exp_mis);
    int r0, w0, dcyc, rcyc, wcyc;
    logic mis;
    r0 = rd_cnt; w0 = wr_cnt;
    dcyc = 0; rcyc = 0; wcyc = 0; mis = 1'b0;
    @(negedge clock);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clock);
    #1 req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (ramR && rcyc == 0) rcyc = n;
      if (ramW && wcyc == 0) wcyc = n;
      if (done) begin
        dcyc = n;
        mis  = misaligned;
        break;
      end
    end
    chk({tag, ".done_cycle"}, dcyc, exp_cyc);
    chk({tag, ".ramR_cycle"}, rcyc, exp_rcyc);
    chk({tag, ".ramW_cycle"}, wcyc, exp_wcyc);
    chk({tag, ".reads"},  rd_cnt - r0, (exp_rcyc != 0) ? 1 : 0);
    chk({tag, ".writes"}, wr_cnt - w0, (exp_wcyc != 0) ? 1 : 0);
    chk({tag, ".misaligned"}, mis, exp_mis);
    if (!w && exp_q.size() > 0) chk({tag, ".rdata"}, rdata, exp_q.pop_front());
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp);
    exp_q.push_back(exp);
    prev_exp = exp;
    xact(tag, 1'b0, f3, a, 32'h0, 3, 1, 0, 1'b0);
  endtask

  initial begin
    int r0, w0, dc;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ramR", ramR, 0);
    chk("rst.ramW", ramW, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.ramAddr", ramAddr, 0);
    chk("rst.ramDataW", ramDataW, 0);
    chk("rst.misaligned", misaligned, 0);
    @(negedge clock);
    nReset = 1'b1;

    // 1. plain word load
    ld("lw14", F3_W, 32'h14, 32'h0000000F);
    chk("lw14.ramAddr", ramAddr, 32'd5);

    // 2. word store then readback
    xact("sw08", 1'b1, F3_W, 32'h08, 32'hDEADBEEF, 2, 0, 1, 1'b0);
    chk("sw08.addr", last_wa, 32'd2);
    chk("sw08.data", last_wd, 32'hDEADBEEF);
    ld("lw08", F3_W, 32'h08, 32'hDEADBEEF);

    // 3. byte read-modify-write and byte loads
    xact("sw_pre3", 1'b1, F3_W, 32'h08, 32'h11223344, 2, 0, 1, 1'b0);
    xact("sb09", 1'b1, F3_B, 32'h09, 32'h000000AA, 4, 1, 3, 1'b0);
    chk("sb09.data", last_wd, 32'h1122AA44);
    chk("sb09.mem", mem[2], 32'h1122AA44);
    ld("lb09", F3_B, 32'h09, 32'hFFFFFFAA);
    ld("lbu09", F3_BU, 32'h09, 32'h000000AA);

    // 4. half loads, both lanes, both extensions
    xact("sw_pre4", 1'b1, F3_W, 32'h08, 32'h80011234, 2, 0, 1, 1'b0);
    ld("lh0a", F3_H, 32'h0A, 32'hFFFF8001);
    ld("lhu0a", F3_HU, 32'h0A, 32'h00008001);
    ld("lh08", F3_H, 32'h08, 32'h00001234);

    // half store into the upper lane
    xact("sh0a", 1'b1, F3_H, 32'h0A, 32'h0000BEEF, 4, 1, 3, 1'b0);
    chk("sh0a.data", last_wd, 32'hBEEF1234);
    ld("lw_sh", F3_W, 32'h08, 32'hBEEF1234);

    // 5. misaligned word load
`ifdef MISALIGN_TRAP_EN
    exp_q.push_back(prev_exp);
    xact("lw16", 1'b0, F3_W, 32'h16, 32'h0, 1, 0, 0, 1'b1);
`else
    ld("lw16", F3_W, 32'h16, 32'h0000000F);
`endif

    // illegal width codes: no RAM access, rdata unchanged
    exp_q.push_back(rdata === 32'hx ? 32'h0 : (exp_q.size() == 0 ?
`ifdef MISALIGN_TRAP_EN
      32'hBEEF1234
`else
      32'h0000000F
`endif
      : 32'h0));
    xact("ill_ld", 1'b0, 3'b011, 32'h14, 32'h0, 1, 0, 0, 1'b0);
    xact("ill_st", 1'b1, F3_BU, 32'h08, 32'h12345678, 1, 0, 0, 1'b0);
    chk("ill_st.mem", mem[2], 32'hBEEF1234);

    // req held during busy: exactly one access, nothing queued
    r0 = rd_cnt; w0 = wr_cnt; dc = 0;
    @(negedge clock);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h14;
    @(posedge clock);
    #1 we = 1'b1; addr = 32'h08; wdata = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        dc = n;
        req = 1'b0;
        break;
      end
    end
    chk("busyreq.done_cycle", dc, 3);
    chk("busyreq.rdata", rdata, 32'h0000000F);
    repeat (3) @(negedge clock);
    chk("busyreq.reads", rd_cnt - r0, 1);
    chk("busyreq.writes", wr_cnt - w0, 0);
    chk("busyreq.idle", busy, 0);

    // 6. reset during RMW_MRG of an SB
    xact("sw_pre6", 1'b1, F3_W, 32'h08, 32'h11223344, 2, 0, 1, 1'b0);
    w0 = wr_cnt;
    @(negedge clock);
    req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h09; wdata = 32'h55;
    @(posedge clock);
    #1 req = 1'b0;
    @(posedge clock);
    #2 nReset = 1'b0;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.ramR", ramR, 0);
    chk("rstmid.ramW", ramW, 0);
    chk("rstmid.rdata", rdata, 0);
    chk("rstmid.ramAddr", ramAddr, 0);
    chk("rstmid.ramDataW", ramDataW, 0);
    repeat (3) @(negedge clock);
    chk("rstmid.writes", wr_cnt - w0, 0);
    chk("rstmid.mem", mem[2], 32'h11223344);
    nReset = 1'b1;
    ld("lw_after_rst", F3_W, 32'h14, 32'h0000000F);

    chk("ramR_ramW_overlap", both_hi, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
